tablero_lector: RTL and testbench

Read-side scanner for the minesweeper board. It takes the 8x8 `tablero` array and cursor position produced by the `buscaminas` game FSM and streams every cell in row-major order over a valid/ready handshake to a downstream consumer (display renderer or serial dump). While streaming, it accumulates revealed-cell and flag totals. It issues a one-cycle completion pulse at the end of each pass.

---
 rtl/buscaminas_pkg.sv | 24 ++
 rtl/indice_tablero.sv | 57 +++++
 rtl/tablero_lector.sv | 149 ++++++++++++++
 tb/tb_tablero_lector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buscaminas_pkg.sv
// Shared minesweeper definitions: board geometry, cell bit layout and
// the board-reader FSM states.
package buscaminas_pkg;

    localparam int FILAS         = 8;
    localparam int COLUMNAS      = 8;
    localparam int ANCHO_CASILLA = 7;

    localparam int BIT_REVELADA = 6;
    localparam int BIT_BANDERA  = 5;
    localparam int BIT_BOMBA    = 4;

    // Wide enough to hold a full-board total (0..64)
    localparam int ANCHO_CONT = 7;

    typedef logic [ANCHO_CASILLA-1:0] casilla_t;

    typedef enum logic [1:0] {
        ESPERA,
        LEYENDO,
        FIN
    } estado_lector_t;

endpackage

// File: rtl/indice_tablero.sv
// Row-major (i,j) cell index with advance enable, clear and last-cell flag.
module indice_tablero #(
    parameter int FILAS    = 8,
    parameter int COLUMNAS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        limpiar,
    input  logic                        avanzar,
    output logic [$clog2(FILAS)-1:0]    idx_i,
    output logic [$clog2(COLUMNAS)-1:0] idx_j,
    output logic                        es_ultima
);

    localparam int AI = $clog2(FILAS);
    localparam int AJ = $clog2(COLUMNAS);

    localparam logic [AI-1:0] I_MAX = AI'(FILAS - 1);
    localparam logic [AJ-1:0] J_MAX = AJ'(COLUMNAS - 1);

    logic [AI-1:0] i_q, i_d;
    logic [AJ-1:0] j_q, j_d;
    logic          fin_fila;

    assign fin_fila = (j_q == J_MAX);

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (limpiar) begin
            i_d = '0;
            j_d = '0;
        end else if (avanzar) begin
            if (fin_fila) begin
                j_d = '0;
                i_d = (i_q == I_MAX) ? '0 : i_q + AI'(1);
            end else begin
                j_d = j_q + AJ'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign idx_i     = i_q;
    assign idx_j     = j_q;
    assign es_ultima = (i_q == I_MAX) && fin_fila;

endmodule

// File: rtl/tablero_lector.sv
// Streams the minesweeper board cell by cell and totals revealed/flagged cells.
// TABLERO_SNAPSHOT_EN: stream a copy of the board captured at pass start.
module tablero_lector #(
    parameter int FILAS         = buscaminas_pkg::FILAS,
    parameter int COLUMNAS      = buscaminas_pkg::COLUMNAS,
    parameter int ANCHO_CASILLA = buscaminas_pkg::ANCHO_CASILLA
) (
    input  logic clk,
    input  logic rst,
    input  logic [FILAS-1:0][COLUMNAS-1:0][ANCHO_CASILLA-1:0] tablero,
    input  logic [$clog2(FILAS)-1:0]                          i_actual,
    input  logic [$clog2(COLUMNAS)-1:0]                       j_actual,
    input  logic                                              iniciar_lectura,
    output logic [ANCHO_CASILLA-1:0]                          casilla_dato,
    output logic [$clog2(FILAS)-1:0]                          casilla_i,
    output logic [$clog2(COLUMNAS)-1:0]                       casilla_j,
    output logic                                              casilla_cursor,
    output logic                                              casilla_valid,
    input  logic                                              casilla_ready,
    output logic                                              casilla_ultima,
    output logic                                              ocupado,
    output logic [buscaminas_pkg::ANCHO_CONT-1:0]             cant_reveladas,
    output logic [buscaminas_pkg::ANCHO_CONT-1:0]             cant_banderas,
    output logic                                              lectura_lista
);

    import buscaminas_pkg::*;

    localparam int AI = $clog2(FILAS);
    localparam int AJ = $clog2(COLUMNAS);

    estado_lector_t estado_q, estado_d;

    logic [ANCHO_CONT-1:0] reveladas_q, reveladas_d;
    logic [ANCHO_CONT-1:0] banderas_q, banderas_d;
    logic                  lista_q, lista_d;

    logic [AI-1:0]            idx_i;
    logic [AJ-1:0]            idx_j;
    logic                     es_ultima;
    logic                     leyendo;
    logic                     inicio;
    logic                     transfer;
    logic [ANCHO_CASILLA-1:0] celda;

    assign leyendo  = (estado_q == LEYENDO);
    assign inicio   = (estado_q == ESPERA) && iniciar_lectura;
    assign transfer = leyendo && casilla_ready;

    indice_tablero #(
        .FILAS    (FILAS),
        .COLUMNAS (COLUMNAS)
    ) u_indice (
        .clk       (clk),
        .rst       (rst),
        .limpiar   (inicio),
        .avanzar   (transfer),
        .idx_i     (idx_i),
        .idx_j     (idx_j),
        .es_ultima (es_ultima)
    );

`ifdef TABLERO_SNAPSHOT_EN
    logic [FILAS-1:0][COLUMNAS-1:0][ANCHO_CASILLA-1:0] foto_q, foto_d;

    always_comb begin
        foto_d = foto_q;
        if (inicio) begin
            foto_d = tablero;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            foto_q <= '0;
        end else begin
            foto_q <= foto_d;
        end
    end

    assign celda = foto_q[idx_i][idx_j];
`else
    assign celda = tablero[idx_i][idx_j];
`endif

    always_comb begin
        estado_d    = estado_q;
        reveladas_d = reveladas_q;
        banderas_d  = banderas_q;
        lista_d     = 1'b0;
        unique case (estado_q)
            ESPERA: begin
                if (iniciar_lectura) begin
                    reveladas_d = '0;
                    banderas_d  = '0;
                    estado_d    = LEYENDO;
                end
            end
            LEYENDO: begin
                if (casilla_ready) begin
                    reveladas_d = reveladas_q
                                + ANCHO_CONT'(celda[BIT_REVELADA]);
                    banderas_d  = banderas_q
                                + ANCHO_CONT'(celda[BIT_BANDERA]);
                    if (es_ultima) begin
                        estado_d = FIN;
                    end
                end
            end
            FIN: begin
                lista_d  = 1'b1;
                estado_d = ESPERA;
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q    <= ESPERA;
            reveladas_q <= '0;
            banderas_q  <= '0;
            lista_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            reveladas_q <= reveladas_d;
            banderas_q  <= banderas_d;
            lista_q     <= lista_d;
        end
    end

    // Beat outputs are forced to zero whenever no beat is being offered
    assign casilla_valid  = leyendo;
    assign casilla_dato   = leyendo ? celda : '0;
    assign casilla_i      = leyendo ? idx_i : '0;
    assign casilla_j      = leyendo ? idx_j : '0;
    assign casilla_ultima = leyendo && es_ultima;
    assign casilla_cursor = leyendo && (idx_i == i_actual)
                                    && (idx_j == j_actual);

    // Busy stays up through the completion-pulse cycle
    assign ocupado        = (estado_q != ESPERA) || lista_q;
    assign lectura_lista  = lista_q;
    assign cant_reveladas = reveladas_q;
    assign cant_banderas  = banderas_q;

endmodule

// File: tb/tb_tablero_lector.sv
// Directed bench for tablero_lector: full pass, stall, cursor, ignored
// starts, held start, mid-pass reset and mid-pass board write.
module tb_tablero_lector;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [7:0][7:0][6:0]      tablero;
    logic [2:0]                i_actual;
    logic [2:0]                j_actual;
    logic                      iniciar_lectura;
    logic [6:0]                casilla_dato;
    logic [2:0]                casilla_i;
    logic [2:0]                casilla_j;
    logic                      casilla_cursor;
    logic                      casilla_valid;
    logic                      casilla_ready;
    logic                      casilla_ultima;
    logic                      ocupado;
    logic [6:0]                cant_reveladas;
    logic [6:0]                cant_banderas;
    logic                      lectura_lista;

    int errs  = 0;
    int total = 0;

    logic [7:0][7:0][6:0] foto_m;

    tablero_lector dut (
        .clk             (clk),
        .rst             (rst),
        .tablero         (tablero),
        .i_actual        (i_actual),
        .j_actual        (j_actual),
        .iniciar_lectura (iniciar_lectura),
        .casilla_dato    (casilla_dato),
        .casilla_i       (casilla_i),
        .casilla_j       (casilla_j),
        .casilla_cursor  (casilla_cursor),
        .casilla_valid   (casilla_valid),
        .casilla_ready   (casilla_ready),
        .casilla_ultima  (casilla_ultima),
        .ocupado         (ocupado),
        .cant_reveladas  (cant_reveladas),
        .cant_banderas   (cant_banderas),
        .lectura_lista   (lectura_lista)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a pass and runs it until lectura_lista, checking every beat
    // against a row-major model of the board.
    task automatic pasada(input int stall_at, input int stall_len,
                          input int pulse_at, input int write_at,
                          input bit mantener, output int ciclos,
                          output int m_rev, output int m_ban);
        int       c;
        int       ei;
        int       ej;
        bit       xfer;
        bit       hecho;
        logic [6:0] cel;
        logic [6:0] esperado;
        ei    = 0;
        ej    = 0;
        m_rev = 0;
        m_ban = 0;
        hecho = 0;
        foto_m          = tablero;
        iniciar_lectura = 1'b1;
        casilla_ready   = 1'b1;
        step();
        c = 0;
        while (c < 300 && !hecho) begin
            if (lectura_lista) begin
                hecho = 1;
            end else begin
`ifdef TABLERO_SNAPSHOT_EN
                esperado = foto_m[ei][ej];
`else
                esperado = tablero[ei][ej];
`endif
                if (casilla_valid) begin
                    check("beat_i", casilla_i, ei);
                    check("beat_j", casilla_j, ej);
                    check("beat_dato", casilla_dato, esperado);
                    check("beat_ultima", casilla_ultima,
                          (ei == 7 && ej == 7));
                    check("beat_cursor", casilla_cursor,
                          (ei == i_actual && ej == j_actual));
                    check("beat_rev", cant_reveladas, m_rev);
                    check("beat_ban", cant_banderas, m_ban);
                    check("beat_ocupado", ocupado, 1);
                end
                casilla_ready   = !(c >= stall_at && c < stall_at + stall_len);
                iniciar_lectura = mantener || (c == pulse_at);
                if (c == write_at) begin
                    tablero[6][0] = 7'b1000000;
                end
`ifdef TABLERO_SNAPSHOT_EN
                cel = foto_m[ei][ej];
`else
                cel = tablero[ei][ej];
`endif
                xfer = casilla_valid && casilla_ready;
                step();
                c++;
                if (xfer) begin
                    m_rev += int'(cel[6]);
                    m_ban += int'(cel[5]);
                    if (ej == 7) begin
                        ej = 0;
                        ei = (ei + 1) % 8;
                    end else begin
                        ej++;
                    end
                end
            end
        end
        if (!hecho) begin
            check("pass_timeout", c, 0);
        end
        check("final_rev", cant_reveladas, m_rev);
        check("final_ban", cant_banderas, m_ban);
        casilla_ready = 1'b1;
        ciclos = c;
    endtask

    initial begin
        int ciclos;
        int mr;
        int mb;
        rst             = 1'b0;
        tablero         = '0;
        i_actual        = 3'd4;
        j_actual        = 3'd5;
        iniciar_lectura = 1'b1;
        casilla_ready   = 1'b1;
        step();
        step();
        check("rst_valid", casilla_valid, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_lista", lectura_lista, 0);
        check("rst_dato", casilla_dato, 0);
        check("rst_ij", {casilla_i, casilla_j}, 0);
        check("rst_cursor", casilla_cursor, 0);
        check("rst_rev", cant_reveladas, 0);
        check("rst_ban", cant_banderas, 0);

        iniciar_lectura = 1'b0;
        tablero[0][0] = 7'b1000011;
        tablero[3][4] = 7'b1000011;
        tablero[7][7] = 7'b1000011;
        tablero[2][2] = 7'b0100000;
        rst = 1'b1;
        step();

        // Plain full pass
        pasada(-1, 0, -1, -1, 0, ciclos, mr, mb);
        check("full_ciclos", ciclos, 65);
        check("full_rev", cant_reveladas, 3);
        check("full_ban", cant_banderas, 1);
        check("full_ocup_pulse", ocupado, 1);
        step();
        check("full_lista_1cyc", lectura_lista, 0);
        check("full_ocupado_off", ocupado, 0);
        check("full_rev_hold", cant_reveladas, 3);

        // Stall at (1,6)
        pasada(14, 5, -1, -1, 0, ciclos, mr, mb);
        check("stall_ciclos", ciclos, 70);
        check("stall_rev", cant_reveladas, 3);
        step();

        // Start pulse mid-pass is ignored
        pasada(-1, 0, 30, -1, 0, ciclos, mr, mb);
        check("pulse_ciclos", ciclos, 65);
        check("pulse_rev", cant_reveladas, 3);
        check("pulse_ban", cant_banderas, 1);
        step();

        // Held start: one idle cycle then the next pass begins
        pasada(-1, 0, -1, -1, 1, ciclos, mr, mb);
        check("held_ciclos", ciclos, 65);
        check("held_gap_valid", casilla_valid, 0);
        step();
        check("held_restart_valid", casilla_valid, 1);
        check("held_restart_ij", {casilla_i, casilla_j}, 0);
        check("held_restart_rev", cant_reveladas, 0);
        iniciar_lectura = 1'b0;

        // Reset after 10 beats of that pass
        for (int k = 0; k < 10; k++) begin
            step();
        end
        check("mid_i", casilla_i, 1);
        check("mid_j", casilla_j, 2);
        check("mid_rev", cant_reveladas, 1);
        rst = 1'b0;
        step();
        check("mrst_valid", casilla_valid, 0);
        check("mrst_rev", cant_reveladas, 0);
        check("mrst_ban", cant_banderas, 0);
        check("mrst_ocupado", ocupado, 0);
        check("mrst_ij", {casilla_i, casilla_j}, 0);
        rst = 1'b1;
        pasada(-1, 0, -1, -1, 0, ciclos, mr, mb);
        check("after_rst_ciclos", ciclos, 65);
        check("after_rst_rev", cant_reveladas, 3);
        step();

        // Board write to (6,0) mid-pass, before it is read
        pasada(-1, 0, -1, 20, 0, ciclos, mr, mb);
        check("write_ciclos", ciclos, 65);
`ifdef TABLERO_SNAPSHOT_EN
        check("write_rev", cant_reveladas, 3);
`else
        check("write_rev", cant_reveladas, 4);
`endif
        check("write_ban", cant_banderas, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
